// File: rtl/race_lt_sequencer_if.sv
// Operand and result handshakes between the control fabric
// and the race-logic less-than sequencer.
interface race_lt_sequencer_if #(
  parameter int VAL_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [VAL_W-1:0] in_a;
  logic [VAL_W-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic             out_fired;
  logic [VAL_W-1:0] out_time;

  modport master (
    output in_valid,
    output in_a,
    output in_b,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_fired,
    input  out_time
  );

  modport slave (
    input  in_valid,
    input  in_a,
    input  in_b,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_fired,
    output out_time
  );
endinterface

// File: rtl/race_lt_sequencer.sv
// One race-logic less-than comparison per gamma cycle:
// latch-set, step-coded inputs, first-arrival time capture.
module race_lt_sequencer #(
  parameter  int GAMMA_CYCLE_WIDTH = 16,
  localparam int VAL_W = $clog2(GAMMA_CYCLE_WIDTH)
) (
  input  logic                aclk,
  input  logic                grst,
  race_lt_sequencer_if.slave  ctl,
  output logic                lt_set,
  output logic                lt_a,
  output logic                lt_b,
  input  logic                lt_q,
  output logic                busy
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    RUN,
    RESULT
  } state_t;

  localparam logic [VAL_W-1:0] LAST =
    VAL_W'(GAMMA_CYCLE_WIDTH - 1);

  state_t           state;
  state_t           state_n;
  logic [VAL_W-1:0] a_reg;
  logic [VAL_W-1:0] b_reg;
  logic [VAL_W-1:0] phase;
  logic             fired;
  logic [VAL_W-1:0] t_reg;

  always_ff @(posedge aclk) begin
    if (grst) state <= IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n       = state;
    ctl.in_ready  = 1'b0;
    ctl.out_valid = 1'b0;
    lt_set        = 1'b0;
    lt_a          = 1'b0;
    lt_b          = 1'b0;
    busy          = (state != IDLE);
    unique case (state)
      IDLE: begin
        ctl.in_ready = 1'b1;
        if (ctl.in_valid) state_n = SETUP;
      end
      SETUP: begin
        lt_set  = 1'b1;
        state_n = RUN;
      end
      RUN: begin
        // Edges come only from registered phase and operands.
        lt_a = (phase >= a_reg);
        lt_b = (phase >= b_reg);
        if (phase == LAST) state_n = RESULT;
      end
      RESULT: begin
        ctl.out_valid = 1'b1;
        if (ctl.out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (grst) begin
      a_reg <= '0;
      b_reg <= '0;
      phase <= '0;
      fired <= 1'b0;
      t_reg <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (ctl.in_valid) begin
            a_reg <= ctl.in_a;
            b_reg <= ctl.in_b;
          end
        end
        SETUP: begin
          phase <= '0;
          fired <= 1'b0;
          t_reg <= '0;
        end
        RUN: begin
          // First arrival wins; later highs are ignored.
          if (lt_q && !fired) begin
            fired <= 1'b1;
            t_reg <= phase;
          end
          if (phase == LAST) phase <= '0;
          else               phase <= phase + VAL_W'(1);
        end
        RESULT: begin
          if (ctl.out_ready) begin
            fired <= 1'b0;
            t_reg <= '0;
          end
        end
        default: phase <= '0;
      endcase
    end
  end

  assign ctl.out_fired = fired;
  assign ctl.out_time  = t_reg;

endmodule

// File: tb/tb_race_lt_sequencer.sv
// Directed bench for race_lt_sequencer with a latching
// less-than comparator model on the lt_* pins.
module tb_race_lt_sequencer;
  localparam int G = 16;
  localparam int W = 4;

  logic aclk = 1'b0;
  logic grst;
  logic lt_set;
  logic lt_a;
  logic lt_b;
  logic lt_q;
  logic busy;
  logic q_hold;
  int   total = 0;
  int   bad   = 0;

  race_lt_sequencer_if #(.VAL_W(W)) bus ();

  race_lt_sequencer #(.GAMMA_CYCLE_WIDTH(G)) dut (
    .aclk   (aclk),
    .grst   (grst),
    .ctl    (bus),
    .lt_set (lt_set),
    .lt_a   (lt_a),
    .lt_b   (lt_b),
    .lt_q   (lt_q),
    .busy   (busy)
  );

  always #5 aclk = ~aclk;

  always @(posedge aclk) begin
    if (grst || lt_set)     q_hold <= 1'b0;
    else if (lt_a && !lt_b) q_hold <= 1'b1;
  end

  assign lt_q = q_hold | (lt_a & ~lt_b);

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", tag, got, want);
    end
  endtask

  task automatic tick;
    @(posedge aclk);
    #1;
  endtask

  task automatic chk_rst(input string nm);
    chk({nm, "_in_ready"}, 32'(bus.in_ready), 1);
    chk({nm, "_lt_set"}, 32'(lt_set), 0);
    chk({nm, "_lt_a"}, 32'(lt_a), 0);
    chk({nm, "_lt_b"}, 32'(lt_b), 0);
    chk({nm, "_out_valid"}, 32'(bus.out_valid), 0);
    chk({nm, "_out_fired"}, 32'(bus.out_fired), 0);
    chk({nm, "_out_time"}, 32'(bus.out_time), 0);
    chk({nm, "_busy"}, 32'(busy), 0);
  endtask

  // Accept a pair, watch the run, check edges and result.
  task automatic run_pair(input int a, input int b,
                          input int fired, input int tme,
                          input int stall, input bit tog,
                          input string nm);
    int c, ra, rb, vc, setcnt;
    bus.in_a      = W'(a);
    bus.in_b      = W'(b);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    chk({nm, "_acc_rdy"}, 32'(bus.in_ready), 1);
    tick();
    bus.in_valid = 1'b0;
    chk({nm, "_setup_set"}, 32'(lt_set), 1);
    chk({nm, "_setup_busy"}, 32'(busy), 1);
    c = 1; ra = 0; rb = 0; vc = 0; setcnt = 0;
    while (vc == 0 && c <= 40) begin
      if (lt_set) setcnt++;
      if (lt_a && ra == 0) ra = c;
      if (lt_b && rb == 0) rb = c;
      if (bus.out_valid) vc = c;
      else begin
        if (tog) begin
          bus.in_valid = 1'($urandom_range(0, 1));
          bus.in_a     = W'($urandom_range(0, 15));
          bus.in_b     = W'($urandom_range(0, 15));
        end
        tick();
        c++;
      end
    end
    bus.in_valid = 1'b0;
    chk({nm, "_nsets"}, 32'(setcnt), 1);
    chk({nm, "_a_rise"}, 32'(ra), 32'(a + 2));
    chk({nm, "_b_rise"}, 32'(rb), 32'(b + 2));
    chk({nm, "_vcycle"}, 32'(vc), 18);
    chk({nm, "_fired"}, 32'(bus.out_fired), 32'(fired));
    chk({nm, "_time"}, 32'(bus.out_time), 32'(tme));
    chk({nm, "_res_rdy"}, 32'(bus.in_ready), 0);
    chk({nm, "_res_lta"}, 32'(lt_a | lt_b), 0);
    for (int i = 0; i < stall; i++) begin
      tick();
      chk({nm, "_st_valid"}, 32'(bus.out_valid), 1);
      chk({nm, "_st_fired"}, 32'(bus.out_fired), 32'(fired));
      chk({nm, "_st_time"}, 32'(bus.out_time), 32'(tme));
      chk({nm, "_st_rdy"}, 32'(bus.in_ready), 0);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk({nm, "_done_valid"}, 32'(bus.out_valid), 0);
    chk({nm, "_done_rdy"}, 32'(bus.in_ready), 1);
    chk({nm, "_done_busy"}, 32'(busy), 0);
  endtask

  initial begin
    int nv;
    grst          = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    chk_rst("reset");
    grst = 1'b0;
    tick();

    run_pair(3, 7, 1, 3, 0, 1'b0, "v1");
    run_pair(9, 2, 0, 0, 0, 1'b0, "v2");
    run_pair(5, 5, 0, 0, 0, 1'b0, "v3eq");
    run_pair(0, 15, 1, 0, 0, 1'b0, "v3lo");
    run_pair(15, 15, 0, 0, 0, 1'b0, "v3hi");
    run_pair(3, 7, 1, 3, 10, 1'b0, "v4");
    run_pair(3, 7, 1, 3, 0, 1'b1, "v5");

    // Reset in the middle of RUN at phase 6.
    bus.in_a     = W'(3);
    bus.in_b     = W'(7);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    repeat (7) tick();
    chk("mid_lt_a", 32'(lt_a), 1);
    chk("mid_lt_b", 32'(lt_b), 0);
    grst = 1'b1;
    tick();
    chk_rst("midrst");
    grst = 1'b0;
    nv = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.out_valid) nv++;
    end
    chk("midrst_novalid", 32'(nv), 0);
    run_pair(1, 4, 1, 1, 0, 1'b0, "v6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
